// File: rtl/ram_dp_clr.sv
// ram_dp_clr: simple dual-port RAM (one write port, one registered read
// port) on a single clock, with a sequential clear engine that zeroes one
// word per cycle while reporting busy.
module ram_dp_clr #(
    parameter int AW      = 3,
    parameter int DW      = 4,
    parameter int RD_MODE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          busy
);

    localparam int N = 1 << AW;

    // The sweep pointer is one bit wider than an address so it can reach N.
    localparam logic [AW:0] PTR_LAST = (AW + 1)'(N - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    logic [DW-1:0] mem [N];

    state_t        state_q,    state_d;
    logic [AW:0]   ptr_q,      ptr_d;
    logic [DW-1:0] rd_data_q,  rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          busy_q,     busy_d;

    // Memory write port, shared between the sweep and normal writes.
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rword;

    // Asynchronous array lookup; the result only ever reaches rd_data via a flop.
    assign mem_rword = mem[rd_addr];

    // Next-state, memory-write and read-data selection logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        busy_d     = busy_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        mem_wdata  = wr_data;

        unique case (state_q)
            ST_CLEAR: begin
                // All requests are ignored while sweeping; rd_data holds.
                mem_we    = 1'b1;
                mem_waddr = ptr_q[AW-1:0];
                mem_wdata = '0;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_READY;
                    busy_d  = 1'b0;
                end
            end

            ST_READY: begin
                if (clear) begin
                    // Clear wins over any read or write in the same cycle.
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    if (wr_en) begin
                        mem_we = 1'b1;
                    end
                    if (rd_en) begin
                        rd_valid_d = 1'b1;
                        // Same-address collision: write-first forwards the
                        // incoming word, read-first returns the old contents.
                        if ((RD_MODE == 1) && wr_en && (wr_addr == rd_addr)) begin
                            rd_data_d = wr_data;
                        end else begin
                            rd_data_d = mem_rword;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    // Control and output registers with synchronous reset into a fresh sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            ptr_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
        end
    end

    // Memory array write; suppressed on reset edges since the sweep restarts.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ram_dp_clr.sv
// Directed bench for ram_dp_clr: one read-first and one write-first
// instance share identical stimulus; expected values are hand-computed.
module tb_ram_dp_clr;

    localparam int AW = 3;
    localparam int DW = 4;

    logic          clk;
    logic          reset;
    logic          clear;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic [DW-1:0] rd_data_rf, rd_data_wf;
    logic          rd_valid_rf, rd_valid_wf;
    logic          busy_rf, busy_wf;

    int npass;
    int ntot;

    ram_dp_clr #(.AW(AW), .DW(DW), .RD_MODE(0)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data_rf),
        .rd_valid (rd_valid_rf),
        .busy     (busy_rf)
    );

    ram_dp_clr #(.AW(AW), .DW(DW), .RD_MODE(1)) u_wf (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data_wf),
        .rd_valid (rd_valid_wf),
        .busy     (busy_wf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Check both instances against the same expectation.
    task automatic chk2(input string tag, input logic [31:0] exp_busy,
                        input logic [31:0] exp_vld, input logic [31:0] exp_data);
        chk({tag, "_busy_rf"}, 32'(busy_rf), exp_busy);
        chk({tag, "_busy_wf"}, 32'(busy_wf), exp_busy);
        chk({tag, "_vld_rf"}, 32'(rd_valid_rf), exp_vld);
        chk({tag, "_vld_wf"}, 32'(rd_valid_wf), exp_vld);
        chk({tag, "_data_rf"}, 32'(rd_data_rf), exp_data);
        chk({tag, "_data_wf"}, 32'(rd_data_wf), exp_data);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        npass = 0;
        ntot  = 0;
        reset = 1'b1;
        idle();
        wr_addr = '0; wr_data = '0; rd_addr = '0;

        // Reset state.
        step();
        chk2("reset", 1, 0, 0);

        // Reset sweep with rd_en held high at address 0.
        reset = 1'b0; rd_en = 1'b1; rd_addr = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk2("rst_sweep", (i < 8) ? 1 : 0, 0, 0);
        end
        step();
        chk2("first_ready", 0, 1, 0);

        // Write 0xA to address 5, then read it back.
        idle(); wr_en = 1'b1; wr_addr = 3'd5; wr_data = 4'hA;
        step();
        chk2("wr5", 0, 0, 0);
        idle(); rd_en = 1'b1; rd_addr = 3'd5;
        step();
        chk2("rd5", 0, 1, 4'hA);
        idle();
        step();
        chk2("rd5_hold", 0, 0, 4'hA);

        // Same-address collision: mem[2]=3, then write 7 and read 2 together.
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'h3;
        step();
        wr_data = 4'h7; rd_en = 1'b1; rd_addr = 3'd2;
        step();
        chk("coll_rf", 32'(rd_data_rf), 32'h3);
        chk("coll_wf", 32'(rd_data_wf), 32'h7);
        chk("coll_vld_rf", 32'(rd_valid_rf), 1);
        chk("coll_vld_wf", 32'(rd_valid_wf), 1);
        idle(); rd_en = 1'b1; rd_addr = 3'd2;
        step();
        chk2("coll_after", 0, 1, 4'h7);

        // Simultaneous write and read at different addresses.
        idle(); wr_en = 1'b1; wr_addr = 3'd4; wr_data = 4'h9; rd_en = 1'b1; rd_addr = 3'd5;
        step();
        chk2("diff_addr", 0, 1, 4'hA);
        idle(); rd_en = 1'b1; rd_addr = 3'd4;
        step();
        chk2("rd4", 0, 1, 4'h9);

        // Fill all words with 0xF.
        idle();
        for (int a = 0; a < 8; a++) begin
            wr_en = 1'b1; wr_addr = 3'(a); wr_data = 4'hF;
            step();
        end
        idle(); rd_en = 1'b1; rd_addr = 3'd6;
        step();
        chk2("fill_rd6", 0, 1, 4'hF);

        // Clear together with a write and a read; clear wins.
        idle(); clear = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h1;
        rd_en = 1'b1; rd_addr = 3'd7;
        step();
        chk2("clr_e0", 1, 0, 4'hF);
        for (int i = 1; i <= 8; i++) begin
            clear = (i == 3);
            wr_en = 1'b1; wr_addr = 3'(i % 8); wr_data = 4'h5;
            rd_en = 1'b1; rd_addr = 3'(i % 8);
            step();
            chk2("clr_sweep", (i < 8) ? 1 : 0, 0, 4'hF);
        end
        idle();
        for (int a = 0; a < 8; a++) begin
            rd_en = 1'b1; rd_addr = 3'(a);
            step();
            chk2("clr_rd", 0, 1, 0);
        end

        // Reset four edges into a sweep, after seeding nonzero data.
        idle(); wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hC;
        step();
        wr_addr = 3'd6; wr_data = 4'hD; rd_en = 1'b1; rd_addr = 3'd3;
        step();
        chk2("seed_rd3", 0, 1, 4'hC);
        idle(); clear = 1'b1;
        step();
        chk2("rs_e0", 1, 0, 4'hC);
        idle();
        for (int i = 1; i <= 4; i++) begin
            step();
            chk2("rs_pre", 1, 0, 4'hC);
        end
        reset = 1'b1;
        step();
        chk2("rs_reset", 1, 0, 0);
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'd6; wr_data = 4'h2;
            step();
            chk2("rs_sweep", (i < 8) ? 1 : 0, 0, 0);
        end
        idle();
        for (int a = 0; a < 8; a++) begin
            rd_en = 1'b1; rd_addr = 3'(a);
            step();
            chk2("rs_rd", 0, 1, 0);
        end

        // Back-to-back write/read traffic after the sweep.
        idle(); wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'hB;
        step();
        wr_addr = 3'd7; wr_data = 4'h6; rd_en = 1'b1; rd_addr = 3'd1;
        step();
        chk2("bb_rd1", 0, 1, 4'hB);
        idle(); rd_en = 1'b1; rd_addr = 3'd7;
        step();
        chk2("bb_rd7", 0, 1, 4'h6);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
